// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among c_NUM_REQ valid/ready producers.
// A grant covers up to c_BURST_LEN words; FIFO full stalls the burst, almost_full blocks new grants.
module fifo_wr_arbiter #(
  parameter int unsigned c_NUM_REQ    = 2,
  parameter int unsigned c_DATA_WIDTH = 16,
  parameter int unsigned c_BURST_LEN  = 4,
  parameter int unsigned c_AF_GATE    = 1
) (
  input  logic                              wr_clk,
  input  logic                              wr_rst,
  input  logic [c_NUM_REQ-1:0]              req_valid,
  input  logic [c_NUM_REQ*c_DATA_WIDTH-1:0] req_data,
  output logic [c_NUM_REQ-1:0]              req_ready,
  output logic                              fifo_wr_en,
  output logic [c_DATA_WIDTH-1:0]           fifo_wr_data,
  input  logic                              fifo_wr_full,
  input  logic                              fifo_almost_full,
  output logic [c_NUM_REQ-1:0]              grant,
  output logic                              busy
);

  localparam int unsigned PTR_W = $clog2(c_NUM_REQ);
  localparam int unsigned CNT_W = $clog2(c_BURST_LEN + 1);
  localparam logic        AF_EN = (c_AF_GATE != 0);

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e                  state_q, state_d;
  logic [c_NUM_REQ-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]        beat_q, beat_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;

  logic                    sel_found;
  logic [PTR_W-1:0]        sel_idx;
  logic                    owner_valid;
  logic [c_DATA_WIDTH-1:0] owner_data;
  logic                    accept;

  // First valid requester strictly after rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr_q;
    for (int k = 1; k <= int'(c_NUM_REQ); k++) begin
      if (!sel_found && req_valid[(int'(rr_ptr_q) + k) % int'(c_NUM_REQ)]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'((int'(rr_ptr_q) + k) % int'(c_NUM_REQ));
      end
    end
  end

  // rr_ptr doubles as the burst owner index while in BURST.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < int'(c_NUM_REQ); i++) begin
      if (rr_ptr_q == PTR_W'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*c_DATA_WIDTH +: c_DATA_WIDTH];
      end
    end
  end

  // Next-state and stream outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    beat_d       = beat_q;
    rr_ptr_d     = rr_ptr_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    accept       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_found && !(AF_EN && fifo_almost_full)) begin
          state_d          = S_BURST;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          rr_ptr_d         = sel_idx;
          beat_d           = '0;
        end
      end
      S_BURST: begin
        req_ready    = grant_q & {c_NUM_REQ{!fifo_wr_full}};
        accept       = owner_valid && !fifo_wr_full;
        fifo_wr_en   = accept;
        fifo_wr_data = owner_data;
        if (!owner_valid || (accept && beat_q == CNT_W'(c_BURST_LEN - 1))) begin
          state_d = S_IDLE;
          grant_d = '0;
          beat_d  = '0;
        end else if (accept) begin
          beat_d = beat_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // No handshake or write may happen in a reset cycle.
    if (wr_rst) begin
      req_ready  = '0;
      fifo_wr_en = 1'b0;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      beat_q   <= '0;
      rr_ptr_q <= PTR_W'(c_NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      beat_q   <= beat_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == S_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers push accepted words, a monitor pops them on
// every FIFO write and compares grant/ready/wr_en against a cycle-level reference of the rules.
module tb_fifo_wr_arbiter;

  localparam int N = 2;
  localparam int W = 16;
  localparam int L = 4;

  logic             wr_clk;
  logic             wr_rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             fifo_wr_en;
  logic [W-1:0]     fifo_wr_data;
  logic             fifo_wr_full;
  logic             fifo_almost_full;
  logic [N-1:0]     grant;
  logic             busy;

  fifo_wr_arbiter #(
    .c_NUM_REQ(N), .c_DATA_WIDTH(W), .c_BURST_LEN(L), .c_AF_GATE(1)
  ) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_full(fifo_wr_full), .fifo_almost_full(fifo_almost_full),
    .grant(grant), .busy(busy)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int          errors = 0;
  int          checks = 0;
  int          mode [N];
  int          full_mode = 0;
  int          af_mode = 0;
  int unsigned seq [N];
  logic [W-1:0] exp_q [N][$];
  logic [W-1:0] wlog [$];
  int          gstart [$];

  // Reference state: owner -1 means idle.
  int          m_owner = -1;
  int          m_cnt = 0;
  int          m_last = N - 1;
  logic [N-1:0] prev_grant = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word(input int id, input int unsigned s);
    return {3'(id), 13'(s)};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wr_clk);
      #1;
    end
  endtask

  // Producers: drive valid/data just after each rising edge.
  initial begin
    forever begin
      @(posedge wr_clk);
      #1;
      for (int i = 0; i < N; i++) begin
        case (mode[i])
          0:       req_valid[i] = 1'b0;
          1:       req_valid[i] = 1'b1;
          default: req_valid[i] = ($urandom_range(3) != 0);
        endcase
        req_data[i*W +: W] = word(i, seq[i]);
      end
      fifo_wr_full     = (full_mode == 1) || (full_mode == 2 && $urandom_range(4) == 0);
      fifo_almost_full = (af_mode == 1) || (af_mode == 2 && $urandom_range(3) == 0);
    end
  end

  // Producer side of the handshake: an accepted word becomes an expected FIFO write.
  initial begin
    forever begin
      @(negedge wr_clk);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] === 1'b1 && req_ready[i] === 1'b1) begin
          exp_q[i].push_back(req_data[i*W +: W]);
          seq[i]++;
        end
      end
    end
  end

  // Monitor: reference prediction for this cycle, compare, then advance the reference.
  initial begin
    logic [N-1:0] e_grant;
    logic [N-1:0] e_ready;
    logic         acc;
    logic [W-1:0] e_word;
    forever begin
      @(negedge wr_clk);
      #1;
      e_grant = '0;
      if (m_owner >= 0) e_grant[m_owner] = 1'b1;
      check("grant", 32'(grant), 32'(e_grant));
      check("busy", 32'(busy), 32'(m_owner >= 0));

      acc     = 1'b0;
      e_ready = '0;
      if (!wr_rst && m_owner >= 0 && !fifo_wr_full) begin
        e_ready = e_grant;
        acc     = req_valid[m_owner];
      end
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("wr_en", 32'(fifo_wr_en), 32'(acc));
      if (fifo_wr_en === 1'b1) begin
        check("wr_en_while_full", 32'(fifo_wr_full), 32'(0));
        wlog.push_back(fifo_wr_data);
      end
      if (fifo_wr_en === 1'b1 && acc) begin
        if (exp_q[m_owner].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_data: got=%0h expected=<none queued> at %0t", fifo_wr_data, $time);
        end else begin
          e_word = exp_q[m_owner].pop_front();
          check("wr_data", 32'(fifo_wr_data), 32'(e_word));
        end
      end

      if (grant != '0 && prev_grant == '0) begin
        for (int i = 0; i < N; i++) if (grant[i]) gstart.push_back(i);
      end
      prev_grant = grant;

      if (wr_rst) begin
        m_owner = -1;
        m_cnt   = 0;
        m_last  = N - 1;
      end else if (m_owner < 0) begin
        if (req_valid != '0 && !fifo_almost_full) begin
          for (int k = 1; k <= N; k++) begin
            if (m_owner < 0 && req_valid[(m_last + k) % N]) m_owner = (m_last + k) % N;
          end
          m_last = m_owner;
          m_cnt  = 0;
        end
      end else if (!req_valid[m_owner]) begin
        m_owner = -1;
      end else if (acc) begin
        m_cnt++;
        if (m_cnt == L) begin
          m_owner = -1;
          m_cnt   = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wr_rst           = 1'b1;
    req_valid        = '0;
    req_data         = '0;
    fifo_wr_full     = 1'b0;
    fifo_almost_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      mode[i] = 1;
      seq[i]  = 0;
    end

    // Reset held with both requesters valid.
    tick(3);
    @(negedge wr_clk);
    #2;
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_wr_en", 32'(fifo_wr_en), 32'(0));
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));

    // Single requester streaming.
    tick(1);
    mode[0] = 1;
    mode[1] = 0;
    wlog.delete();
    wr_rst = 1'b0;
    tick(14);
    check("single_n_writes", 32'(wlog.size() >= 5), 32'(1));
    for (int i = 0; i < 5 && i < wlog.size(); i++)
      check("single_data_seq", 32'(wlog[i]), 32'(word(0, i)));

    // Round robin after reset: req0 first, then alternate.
    wr_rst = 1'b1;
    mode[0] = 1;
    mode[1] = 1;
    tick(2);
    gstart.delete();
    wr_rst = 1'b0;
    tick(20);
    check("rr_n_grants", 32'(gstart.size() >= 3), 32'(1));
    if (gstart.size() >= 3) begin
      check("rr_grant0", 32'(gstart[0]), 32'(0));
      check("rr_grant1", 32'(gstart[1]), 32'(1));
      check("rr_grant2", 32'(gstart[2]), 32'(0));
    end

    // Full stall mid-burst.
    tick(2);
    full_mode = 1;
    tick(5);
    full_mode = 0;
    tick(12);

    // Almost full blocks new bursts but lets the running one finish.
    af_mode = 1;
    tick(10);
    check("af_no_grant", 32'(grant), 32'(0));
    check("af_not_busy", 32'(busy), 32'(0));
    af_mode = 0;
    tick(8);

    // Owner going idle ends bursts early.
    mode[0] = 0;
    mode[1] = 2;
    tick(30);

    // Reset mid-burst: req0 regains first priority.
    mode[0] = 1;
    mode[1] = 1;
    tick(7);
    wr_rst = 1'b1;
    tick(1);
    gstart.delete();
    wr_rst = 1'b0;
    tick(4);
    check("rst_mid_n_grants", 32'(gstart.size() >= 1), 32'(1));
    if (gstart.size() >= 1) check("rst_mid_first_req0", 32'(gstart[0]), 32'(0));

    // Random traffic with stalls, almost_full and occasional resets.
    mode[0]   = 2;
    mode[1]   = 2;
    full_mode = 2;
    af_mode   = 2;
    for (int c = 0; c < 800; c++) begin
      wr_rst = ($urandom_range(99) == 0);
      tick(1);
    end
    wr_rst = 1'b0;

    // Drain: every accepted word must have been written.
    mode[0]   = 0;
    mode[1]   = 0;
    full_mode = 0;
    af_mode   = 0;
    tick(10);
    for (int i = 0; i < N; i++) check("no_lost_words", 32'(exp_q[i].size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
